// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned TIMER_W = 8;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DONE      = 2'd3
    } lsu_state_t;

    // RV32I funct3 size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Opcodes shared with the control unit
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Latched bus request payload
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } bus_req_t;

    // Stores only have signed-looking encodings; the unsigned forms are load-only
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~is_store;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus: req/gnt address phase, rvalid response phase.
interface lsu_mem_ctrl_if;
    import lsu_pkg::*;

    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [BE_W-1:0] bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

endinterface

// File: rtl/lsu_align.sv
// Access sizing: legality, alignment, byte enables, store lane replication, load extraction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic            i_store,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic            o_legal_c,
    output logic            o_aligned_c,
    output logic [BE_W-1:0] o_be_c,
    output logic [XLEN-1:0] o_wdata_c,
    output logic [XLEN-1:0] o_rdata_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select from the low address bits
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    // Size decode per funct3
    always_comb begin
        o_legal_c   = f3_legal(i_funct3, i_store);
        o_aligned_c = 1'b0;
        o_be_c      = '0;
        o_wdata_c   = '0;
        o_rdata_c   = '0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_aligned_c = 1'b1;
                o_be_c      = BE_W'(4'b0001 << i_addr_lo);
                o_wdata_c   = {4{i_wdata[7:0]}};
                o_rdata_c   = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte}
                                                 : {24'd0, w_byte};
            end
            F3_H, F3_HU: begin
                o_aligned_c = ~i_addr_lo[0];
                o_be_c      = BE_W'(4'b0011 << {i_addr_lo[1], 1'b0});
                o_wdata_c   = {2{i_wdata[15:0]}};
                o_rdata_c   = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half}
                                                 : {16'd0, w_half};
            end
            F3_W: begin
                o_aligned_c = (i_addr_lo == 2'b00);
                o_be_c      = 4'b1111;
                o_wdata_c   = i_wdata;
                o_rdata_c   = i_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: sequences one data-memory access per instruction and stalls the pipe meanwhile.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata_out,
    output logic            stall,
    output logic            access_err,
    output logic            bus_err_out,
    lsu_mem_ctrl_if.master  bus
);

    lsu_state_t         r_state;
    bus_req_t           r_req;
    logic               r_bus_req;
    logic [2:0]         r_funct3;
    logic [1:0]         r_addr_lo;
    logic [TIMER_W-1:0] r_timer;
    logic [XLEN-1:0]    r_rdata;
    logic               r_access_err;
    logic               r_bus_err;

    logic               w_idle;
    logic               w_access;
    logic               w_ok;
    logic               w_timeout;
    logic [2:0]         w_f3_sel;
    logic [1:0]         w_lo_sel;
    logic               w_store_sel;
    logic               w_legal;
    logic               w_aligned;
    logic [BE_W-1:0]    w_be;
    logic [XLEN-1:0]    w_wdata_rep;
    logic [XLEN-1:0]    w_rdata_ext;

    // One aligner serves both phases: live request in IDLE, latched request afterwards
    assign w_idle      = (r_state == ST_IDLE);
    assign w_f3_sel    = w_idle ? funct3 : r_funct3;
    assign w_lo_sel    = w_idle ? addr[1:0] : r_addr_lo;
    assign w_store_sel = w_idle ? mem_write : r_req.we;

    lsu_align u_align (
        .i_funct3    (w_f3_sel),
        .i_addr_lo   (w_lo_sel),
        .i_store     (w_store_sel),
        .i_wdata     (wdata),
        .i_rdata     (bus.bus_rdata),
        .o_legal_c   (w_legal),
        .o_aligned_c (w_aligned),
        .o_be_c      (w_be),
        .o_wdata_c   (w_wdata_rep),
        .o_rdata_c   (w_rdata_ext)
    );

    // Request qualification; simultaneous read and write is rejected
    assign w_access  = mem_read | mem_write;
    assign w_ok      = w_legal & w_aligned & ~(mem_read & mem_write);
    assign w_timeout = (r_timer == TIMER_W'(TIMEOUT - 1));

    // Stall covers the issuing IDLE cycle through the response; DONE releases the pipe
    assign stall = (w_idle & w_access & w_ok)
                 | (r_state == ST_REQ)
                 | (r_state == ST_WAIT_RESP);

    // Access sequencer with registered bus and result outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_bus_req    <= 1'b0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
            r_timer      <= '0;
            r_rdata      <= '0;
            r_access_err <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_access_err <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access && w_ok) begin
                        r_req.we    <= mem_write;
                        r_req.addr  <= {addr[XLEN-1:2], 2'b00};
                        r_req.be    <= w_be;
                        r_req.wdata <= w_wdata_rep;
                        r_funct3    <= funct3;
                        r_addr_lo   <= addr[1:0];
                        r_timer     <= '0;
                        r_bus_req   <= 1'b1;
                        r_state     <= ST_REQ;
                    end else if (w_access) begin
                        r_access_err <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= ST_DONE;
                    end else if (bus.bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.bus_rvalid) begin
                        r_rdata   <= r_req.we ? '0 : w_rdata_ext;
                        r_bus_err <= bus.bus_err;
                        r_state   <= ST_DONE;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output mapping
    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_req.we;
    assign bus.bus_addr  = r_req.addr;
    assign bus.bus_be    = r_req.be;
    assign bus.bus_wdata = r_req.wdata;
    assign rdata_out     = r_rdata;
    assign access_err    = r_access_err;
    assign bus_err_out   = r_bus_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a cycle-level memory responder.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_out;
    logic        stall;
    logic        access_err;
    logic        bus_err_out;

    int n_vec = 0;
    int n_err = 0;

    // Observations from the last access
    int          n_stall;
    int          n_req;
    logic [3:0]  o_be;
    logic [31:0] o_wd;
    logic        o_we;
    logic [31:0] o_addr;
    logic [31:0] o_rdata;
    logic        o_berr;

    lsu_mem_ctrl_if bif ();

    lsu_mem_ctrl #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .rdata_out   (rdata_out),
        .stall       (stall),
        .access_err  (access_err),
        .bus_err_out (bus_err_out),
        .bus         (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one access and play memory: gnt after gnt_dly REQ cycles, rvalid rsp_dly cycles after the first WAIT cycle
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int gnt_dly, input int rsp_dly,
                              input logic [31:0] rsp_data, input logic rsp_err);
        bit granted;
        bit done;
        int wait_n;
        int cyc;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        n_stall = 0; n_req = 0; granted = 0; done = 0; wait_n = 0; cyc = 0;
        o_be = '0; o_wd = '0; o_we = 1'b0; o_addr = '0; o_rdata = '0; o_berr = 1'b0;
        while (!done && cyc < 64) begin
            bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0;
            bif.bus_rdata = 32'h5555_5555; bif.bus_err = 1'b0;
            if (bif.bus_req) begin
                n_req++;
                if (n_req == 1) begin
                    o_be = bif.bus_be; o_wd = bif.bus_wdata;
                    o_we = bif.bus_we; o_addr = bif.bus_addr;
                end
                if (n_req > gnt_dly) begin
                    bif.bus_gnt = 1'b1;
                    granted = 1;
                end
            end else if (granted) begin
                wait_n++;
                if (wait_n > rsp_dly) begin
                    bif.bus_rvalid = 1'b1; bif.bus_rdata = rsp_data; bif.bus_err = rsp_err;
                    granted = 0;
                end
            end
            #1;
            if (stall) begin
                n_stall++;
            end else if (n_stall > 0) begin
                done = 1;
                o_rdata = rdata_out; o_berr = bus_err_out;
                mem_read = 1'b0; mem_write = 1'b0;
            end
            cyc++;
            if (!done) @(negedge clk);
        end
        if (!done) chk("access_completed", 32'd0, 32'd1);
        bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0;
    endtask

    // Rejected access: no stall, no request, one-cycle access_err
    task automatic run_bad(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a);
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk({tag, "_err_pulse"}, 32'(access_err), 32'd1);
        chk({tag, "_no_req"}, 32'(bif.bus_req), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_err_clear"}, 32'(access_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = '0; wdata = '0;
        bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0; bif.bus_err = 1'b0;
        #12;
        chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("rst_bus_be", 32'(bif.bus_be), 32'd0);
        chk("rst_bus_addr", bif.bus_addr, 32'd0);
        chk("rst_bus_wdata", bif.bus_wdata, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // LW, immediate gnt, response one cycle later
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        chk("lw_stall", 32'(n_stall), 32'd3);
        chk("lw_req_cycles", 32'(n_req), 32'd1);
        chk("lw_be", 32'(o_be), 32'hF);
        chk("lw_addr", o_addr, 32'h100);
        chk("lw_we", 32'(o_we), 32'd0);
        chk("lw_rdata", o_rdata, 32'hDEAD_BEEF);
        chk("lw_berr", 32'(o_berr), 32'd0);

        // Byte and half loads, signed and unsigned
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h8012_3456, 1'b0);
        chk("lb_be", 32'(o_be), 32'h8);
        chk("lb_addr", o_addr, 32'h100);
        chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h8012_3456, 1'b0);
        chk("lbu_rdata", o_rdata, 32'h0000_0080);
        run_access(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 0, 1, 32'h0000_8001, 1'b0);
        chk("lh_be", 32'(o_be), 32'h3);
        chk("lh_rdata", o_rdata, 32'hFFFF_8001);
        chk("lh_stall", 32'(n_stall), 32'd4);
        run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'hBEEF_1234, 1'b0);
        chk("lhu_be", 32'(o_be), 32'hC);
        chk("lhu_rdata", o_rdata, 32'h0000_BEEF);

        // Stores: delayed gnt, lane replication, read data ignored
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 4, 0, 32'h7777_7777, 1'b0);
        chk("sh_req_cycles", 32'(n_req), 32'd5);
        chk("sh_stall", 32'(n_stall), 32'd7);
        chk("sh_be", 32'(o_be), 32'hC);
        chk("sh_wdata", o_wd, 32'hABCD_ABCD);
        chk("sh_we", 32'(o_we), 32'd1);
        chk("sh_addr", o_addr, 32'h200);
        chk("sh_rdata_zero", o_rdata, 32'd0);
        run_access(1'b0, 1'b1, 3'b000, 32'h001, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
        chk("sb_be", 32'(o_be), 32'h2);
        chk("sb_wdata", o_wd, 32'hA5A5_A5A5);
        chk("sb_addr", o_addr, 32'h0);
        run_access(1'b0, 1'b1, 3'b010, 32'h300, 32'h1122_3344, 1, 2, 32'h0, 1'b0);
        chk("sw_be", 32'(o_be), 32'hF);
        chk("sw_wdata", o_wd, 32'h1122_3344);

        // Rejected accesses
        run_bad("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h101);
        run_bad("f3_011", 1'b1, 1'b0, 3'b011, 32'h100);
        run_bad("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h100);
        run_bad("sh_misalign", 1'b0, 1'b1, 3'b001, 32'h203);
        run_bad("store_f3_100", 1'b0, 1'b1, 3'b100, 32'h100);

        // Bus error reported in DONE
        run_access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 0, 0, 32'h1357_9BDF, 1'b1);
        chk("berr_flag", 32'(o_berr), 32'd1);

        // Timeout with no gnt, then a normal access
        run_access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0);
        chk("pre_to_rdata", o_rdata, 32'h1357_9BDF);
        chk("pre_to_berr", 32'(o_berr), 32'd0);
        run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1000, 0, 32'h0, 1'b0);
        chk("to_req_cycles", 32'(n_req), 32'd8);
        chk("to_stall", 32'(n_stall), 32'd9);
        chk("to_berr", 32'(o_berr), 32'd1);
        chk("to_rdata", o_rdata, 32'd0);
        @(negedge clk);
        #1;
        chk("to_berr_pulse_end", 32'(bus_err_out), 32'd0);
        run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0);
        chk("post_to_rdata", o_rdata, 32'hCAFE_F00D);
        chk("post_to_berr", 32'(o_berr), 32'd0);

        // Reset while REQ: bus_req drops without a clock edge
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        #1;
        chk("rq_req_before", 32'(bif.bus_req), 32'd1);
        reset_n = 1'b0; mem_read = 1'b0;
        #1;
        chk("rq_req_async", 32'(bif.bus_req), 32'd0);
        chk("rq_stall_async", 32'(stall), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset while WAIT_RESP, then a late response is ignored
        run_access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 0, 0, 32'h2468_ACE0, 1'b0);
        chk("pre_rst_rdata", o_rdata, 32'h2468_ACE0);
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk);
        bif.bus_gnt = 1'b1;
        @(negedge clk);
        bif.bus_gnt = 1'b0;
        #1;
        chk("wr_stall_before", 32'(stall), 32'd1);
        reset_n = 1'b0; mem_read = 1'b0;
        #1;
        chk("wr_stall_async", 32'(stall), 32'd0);
        chk("wr_req_async", 32'(bif.bus_req), 32'd0);
        chk("wr_rdata_reset", rdata_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF; bif.bus_err = 1'b1;
        @(negedge clk);
        bif.bus_rvalid = 1'b0; bif.bus_err = 1'b0;
        #1;
        chk("late_rdata", rdata_out, 32'd0);
        chk("late_berr", 32'(bus_err_out), 32'd0);
        chk("late_stall", 32'(stall), 32'd0);
        chk("late_req", 32'(bif.bus_req), 32'd0);
        run_access(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 0, 0, 32'h0F0F_F0F0, 1'b0);
        chk("post_rst_rdata", o_rdata, 32'h0F0F_F0F0);
        chk("post_rst_stall", 32'(n_stall), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
